// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply controller for base^exponent mod N; every product is
// handed to an external mod-N reduction responder. Optional wait timeout: RED_TIMEOUT_EN.
module rsa_modexp_ctrl #(
  parameter int DATA_W = 6,
  parameter int EXP_W  = 6,
  parameter int OPER_W = 18
`ifdef RED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] base,
  input  logic [EXP_W-1:0]  exponent,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              red_req,
  output logic [OPER_W-1:0] red_operand,
  input  logic              red_valid,
  input  logic [DATA_W-1:0] red_result
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {IDLE, RBASE, SQ, SQW, MUL, MULW, FIN} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   base_q, base_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [OPER_W-1:0]   oper_q, oper_d;
  logic                red_req_q, red_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                timeout;

  // Full-width product, zero-extended to the reduction operand width.
  function automatic logic [OPER_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return OPER_W'(p);
  endfunction

`ifdef RED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  // The first RBASE cycle carries the request itself, so it is not a wait cycle.
  assign waiting = (state_q == SQW) || (state_q == MULW) ||
                   ((state_q == RBASE) && !red_req_q);
  // Counting the request cycle as 0, FIN (done+err) lands in cycle TIMEOUT_CYC.
  assign timeout = waiting && !red_valid && (cnt_q == CNT_W'(TIMEOUT_CYC - 2));

  always_comb begin
    cnt_d = cnt_q;
    if (red_req_q) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    exp_d     = exp_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    result_d  = result_q;
    oper_d    = oper_q;
    red_req_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base;
          exp_d     = exponent;
          acc_d     = DATA_W'(1);
          idx_d     = IDX_W'(EXP_W - 1);
          oper_d    = OPER_W'(base);
          red_req_d = 1'b1;
          state_d   = RBASE;
        end
      end
      RBASE: begin
        if (red_valid && !red_req_q) begin
          base_d  = red_result;
          state_d = SQ;
        end
      end
      SQ: state_d = SQW;
      SQW: begin
        if (red_valid) begin
          acc_d = red_result;
          if (exp_q[idx_q]) begin
            state_d = MUL;
          end else if (idx_q == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQ;
          end
        end
      end
      MUL: state_d = MULW;
      MULW: begin
        if (red_valid) begin
          acc_d = red_result;
          if (idx_q == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQ;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = FIN;
    end

    // Requests are registered: operand and strobe appear in the SQ/MUL cycle itself.
    if ((state_d == SQ) || (state_d == MUL)) begin
      red_req_d = 1'b1;
      oper_d    = mul_ext(acc_d, (state_d == MUL) ? base_q : acc_d);
    end

    if (state_d == FIN) begin
      done_d   = 1'b1;
      err_d    = timeout;
      result_d = timeout ? '0 : acc_d;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      exp_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      result_q  <= '0;
      oper_q    <= '0;
      red_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      exp_q     <= exp_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      oper_q    <= oper_d;
      red_req_q <= red_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign result      = result_q;
  assign red_req     = red_req_q;
  assign red_operand = oper_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl with a mod-55 reduction responder model.
module tb_rsa_modexp_ctrl;

  localparam int DATA_W      = 6;
  localparam int EXP_W       = 6;
  localparam int OPER_W      = 18;
  localparam int TIMEOUT_CYC = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] base;
  logic [EXP_W-1:0]  exponent;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic              red_req;
  logic [OPER_W-1:0] red_operand;
  logic              red_valid;
  logic [DATA_W-1:0] red_result;

  int n_chk  = 0;
  int n_pass = 0;

  // Written only by the responder process.
  int                nreq = 0;
  int                stab_bad = 0;
  int                stray_seen = 0;
  logic [OPER_W-1:0] ops[$];

  // Written only by the main process.
  bit resp_en  = 1'b1;
  int resp_lat = 1;
  int stray_tok = 0;
  int last_op0 = 0;

  rsa_modexp_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base        (base),
    .exponent    (exponent),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .result      (result),
    .red_req     (red_req),
    .red_operand (red_operand),
    .red_valid   (red_valid),
    .red_result  (red_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mod-55 responder: latency resp_lat cycles (0 selects random 1..10).
  initial begin
    logic [OPER_W-1:0] op;
    int lat;
    bit aborted;
    red_valid  = 1'b0;
    red_result = '0;
    forever begin
      @(negedge clk);
      if (stray_tok != stray_seen) begin
        stray_seen = stray_tok;
        red_valid  = 1'b1;
        red_result = 6'd33;
        @(negedge clk);
        red_valid  = 1'b0;
      end else if (resp_en && red_req === 1'b1) begin
        op = red_operand;
        ops.push_back(op);
        nreq++;
        lat = (resp_lat == 0) ? $urandom_range(10, 1) : resp_lat;
        aborted = 1'b0;
        repeat (lat) begin
          @(posedge clk);
          #1;
          if (!rst_n) aborted = 1'b1;
          if (!aborted && red_operand !== op) stab_bad++;
        end
        if (!aborted) begin
          red_valid  = 1'b1;
          red_result = DATA_W'(op % 55);
          @(posedge clk);
          #1;
          red_valid  = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input string tag, input logic [DATA_W-1:0] b,
                        input logic [EXP_W-1:0] e, input int exp_res,
                        input int exp_req, input bit inject);
    int n0;
    bit seen;
    @(negedge clk);
    n0       = nreq;
    last_op0 = ops.size();
    base     = b;
    exponent = e;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    seen = 1'b0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      if (inject && cyc == 5) begin
        start    = 1'b1;
        base     = 6'd1;
        exponent = 6'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_nreq"}, nreq - n0, exp_req);
    @(negedge clk);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_done_off"}, done, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", red_req, 0);
    chk("rst_result", result, 0);
    chk("rst_oper", red_operand, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("p2e3", 6'd2, 6'd3, 8, 9, 1'b0);
    chk("p2e3_op0", ops[last_op0], 2);
    chk("p2e3_op6", ops[last_op0 + 6], 2);
    chk("p2e3_op8", ops[last_op0 + 8], 8);

    run_op("enc", 6'd13, 6'd3, 52, 9, 1'b0);
    run_op("dec", 6'd52, 6'd27, 13, 11, 1'b0);

    run_op("b60", 6'd60, 6'd2, 25, 8, 1'b0);
    chk("b60_op0", ops[last_op0], 60);
    chk("b60_mulop", ops[last_op0 + 6], 5);
    chk("b60_lastop", ops[last_op0 + 7], 25);

    run_op("e0", 6'd9, 6'd0, 1, 7, 1'b0);

    // Stray red_valid in IDLE must be ignored.
    stray_tok++;
    repeat (3) @(negedge clk);
    chk("stray_busy", busy, 0);
    chk("stray_req", red_req, 0);

    resp_lat = 0;
    run_op("rnd", 6'd7, 6'd3, 13, 9, 1'b1);
    chk("rnd_stable", stab_bad, 0);

    // Asynchronous reset while waiting in SQW.
    resp_lat = 5;
    begin
      int n0;
      bit hit;
      @(negedge clk);
      n0       = nreq;
      base     = 6'd2;
      exponent = 6'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge clk);
        #1;
        if (nreq - n0 >= 3) hit = 1'b1;
      end
      chk("rstmid_reached", hit, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      chk("rstmid_err", err, 0);
      chk("rstmid_req", red_req, 0);
      chk("rstmid_oper", red_operand, 0);
      chk("rstmid_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("rstmid_idle", busy, 0);
    end
    resp_lat = 1;
    run_op("after_rst", 6'd2, 6'd5, 32, 9, 1'b0);

`ifdef RED_TIMEOUT_EN
    resp_en = 1'b0;
    begin
      int k;
      bit seen;
      @(negedge clk);
      base     = 6'd3;
      exponent = 6'd1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen  = 1'b0;
      k     = 0;
      for (int i = 0; i <= 4 * TIMEOUT_CYC && !seen; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          k    = i;
        end
      end
      chk("to_done_seen", seen, 1);
      chk("to_cycle", k, TIMEOUT_CYC);
      chk("to_err", err, 1);
      chk("to_result", result, 0);
      @(negedge clk);
      chk("to_busy_off", busy, 0);
      chk("to_err_off", err, 0);
    end
    resp_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
